fifo_sync_flow: RTL and testbench
=================================

// Module: fifo_sync_flow
// PURPOSE
//  Single-clock parametrised data FIFO with valid-in / ready-out flow control.
//  - Buffers a DW-bit stream from an upstream producer to a downstream consumer in the same clock domain.
//  - Generalises the fixed 16x64 stream FIFO: parametrised width, depth and almost-full level, plus status flags.
//  - Adds a saturating drop counter and a sticky overflow flag for words lost while full.
// PARAMETERS
//  DW        16   data width, bits
//  AW        6    address width; DEPTH = 2**AW entries
//  AF_LEVEL  61   almost_full asserts when usedw >= AF_LEVEL; legal range 1..2**AW
//  CW        16   drop counter width
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst          in   1      synchronous reset, active high
//  din          in   DW     write data
//  din_vld      in   1      write data valid
//  din_rdy      out  1      FIFO can accept a word this cycle (= !full)
//  almost_full  out  1      usedw >= AF_LEVEL; upstream should stop sending
//  b_rdy        in   1      downstream ready to accept a word
//  dout         out  DW     read data, registered
//  dout_vld     out  1      dout valid, one cycle pulse per word
//  usedw        out  AW+1   words currently stored, 0..2**AW
//  empty        out  1      usedw == 0
//  full         out  1      usedw == 2**AW
//  clr_stat     in   1      clears drop_cnt and ovf_sticky
//  drop_cnt     out  CW     words offered while full, saturating
//  ovf_sticky   out  1      set on the first dropped word, held until clr_stat or rst
// BEHAVIOUR
//  Reset (rst=1 at a clock edge)
//   - Pointers and usedw go to 0; empty=1, full=0, almost_full=0 (AF_LEVEL>=1), din_rdy=1.
//   - dout=0, dout_vld=0, drop_cnt=0, ovf_sticky=0. RAM contents are not cleared.
//   - Reset mid-stream discards all stored words; no dout_vld follows the reset edge.
//  Write and read qualification
//   - wr = din_vld && !full. Stores din at wr_ptr, then wr_ptr++ (mod 2**AW).
//   - rd = b_rdy && !empty. rd_ptr++ (mod 2**AW).
//   - Pointers are AW+1 bits. full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
//  Output latency
//   - dout <= mem[rd_ptr] and dout_vld <= 1 in the cycle after rd.
//   - Otherwise dout_vld <= 0 and dout holds its last value.
//   - A word written in cycle N is readable (empty=0) in cycle N+1 and appears on dout at N+2 at the earliest.
//  Occupancy
//   - usedw: +1 on wr only, -1 on rd only, unchanged on both or neither.
//   - empty, full, almost_full and din_rdy are combinational decodes of the registered pointers and usedw.
//  Simultaneous events
//   - Full with din_vld and rd in the same cycle: the write is rejected (full decoded pre-edge) and the word is dropped.
//   - Empty with din_vld and b_rdy in the same cycle: write only, no read.
//   - Otherwise wr and rd together: both proceed, usedw unchanged.
//  Drop accounting
//   - When din_vld && full: drop_cnt increments, saturating at 2**CW-1, and ovf_sticky <= 1.
//   - clr_stat takes priority over a same-cycle drop: both go to 0.
//  Streaming
//   - b_rdy held high: one word per cycle, no bubbles while non-empty.
//   - b_rdy low: no reads; the stored data and dout are preserved.
// TESTING
//  1. Reset, then write 0x0001..0x0003 with b_rdy=0
//     -> usedw=3, empty=0, dout_vld=0. Raise b_rdy -> dout 1,2,3 on consecutive cycles, vld high 3 cycles, empty=1.
//  2. Fill 64 words (AW=6), b_rdy=0
//     -> almost_full at usedw=61, full and din_rdy=0 at 64.
//     -> 3 more din_vld -> drop_cnt=3, ovf_sticky=1, usedw=64.
//  3. Full, then din_vld=1 and b_rdy=1 for one cycle
//     -> write dropped (drop_cnt+1), usedw=63, and the next dout is the oldest word.
//  4. Continuous write and read from empty for 200 cycles, data = counter
//     -> dout sequence equals the input delayed 2 cycles, no gaps or duplicates, usedw<=1.
//  5. Assert rst with 10 words stored
//     -> next cycle usedw=0, empty=1, dout=0, dout_vld=0; no stale word is output afterwards.
//  6. drop_cnt forced near saturation (CW=4, 20 drops)
//     -> holds at 15. Then clr_stat and a drop in the same cycle -> drop_cnt=0, ovf_sticky=0.

Source files
------------

// File: rtl/fifo_sync_flow.sv
// ---------------------------------------------------------------------------
// fifo_sync_flow
// Single-clock data FIFO with valid/ready flow control, occupancy flags and
// drop accounting for words offered while the FIFO is full.
//
// Parameters
//   DW        data width in bits
//   AW        address width; the FIFO holds 2**AW words
//   AF_LEVEL  almost_full threshold on usedw (1..2**AW)
//   CW        drop counter width
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active high
//   din          in   write data
//   din_vld      in   write data valid
//   din_rdy      out  FIFO can accept a word (= !full)
//   almost_full  out  usedw >= AF_LEVEL
//   b_rdy        in   downstream ready
//   dout         out  registered read data
//   dout_vld     out  one-cycle pulse per word on dout
//   usedw        out  words stored, 0..2**AW
//   empty        out  usedw == 0
//   full         out  usedw == 2**AW
//   clr_stat     in   clears drop_cnt and ovf_sticky
//   drop_cnt     out  saturating count of words offered while full
//   ovf_sticky   out  set on first dropped word, held until clr_stat/rst
// ---------------------------------------------------------------------------
module fifo_sync_flow #(
  parameter int DW       = 16,
  parameter int AW       = 6,
  parameter int AF_LEVEL = 61,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  output logic          din_rdy,
  output logic          almost_full,
  input  logic          b_rdy,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic [AW:0]   usedw,
  output logic          empty,
  output logic          full,
  input  logic          clr_stat,
  output logic [CW-1:0] drop_cnt,
  output logic          ovf_sticky
);

  localparam int          DEPTH    = 2 ** AW;
  localparam logic [AW:0] AF_THR   = (AW + 1)'(AF_LEVEL);
  localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
  localparam logic [CW-1:0] DROP_MAX = '1;
  localparam logic [CW-1:0] DROP_ONE = CW'(1);

  logic [DW-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty can be told apart
  // when the low address bits are equal.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] cnt;

  logic wr;
  logic rd;
  logic drop;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == DROP_MAX) ? v : v + DROP_ONE;
  endfunction

  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty       = (wr_ptr == rd_ptr);
  assign almost_full = (cnt >= AF_THR);
  assign din_rdy     = !full;
  assign usedw       = cnt;

  // Full is decoded from pre-edge state, so a read in the same cycle does
  // not make room for a write; that word is counted as dropped.
  assign wr   = din_vld && !full;
  assign rd   = b_rdy && !empty;
  assign drop = din_vld && full;

  // Stage p0: pointer and occupancy update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd) rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({wr, rd})
        2'b10:   cnt <= cnt + PTR_ONE;
        2'b01:   cnt <= cnt - PTR_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is left uninitialised; reset only moves the pointers.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Stage p1: registered read port; dout holds its value between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= rd;
      if (rd) dout <= mem[rd_ptr[AW-1:0]];
    end
  end

  // Drop statistics; clr_stat wins over a drop in the same cycle
  always_ff @(posedge clk) begin
    if (rst || clr_stat) begin
      drop_cnt   <= '0;
      ovf_sticky <= 1'b0;
    end else if (drop) begin
      drop_cnt   <= sat_inc(drop_cnt);
      ovf_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_sync_flow.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_flow
// Self-checking bench for fifo_sync_flow: a table of directed vectors, hand
// sequences for fill/overflow/reset/saturation corners, and a randomized run.
// A queue-based reference model is compared against every output each cycle.
// ---------------------------------------------------------------------------
module tb_fifo_sync_flow;

  localparam int DW    = 16;
  localparam int AW    = 6;
  localparam int AF    = 61;
  localparam int CW    = 4;
  localparam int DEPTH = 2 ** AW;
  localparam int DMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_vld;
  logic          din_rdy;
  logic          almost_full;
  logic          b_rdy;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic [AW:0]   usedw;
  logic          empty;
  logic          full;
  logic          clr_stat;
  logic [CW-1:0] drop_cnt;
  logic          ovf_sticky;

  fifo_sync_flow #(.DW(DW), .AW(AW), .AF_LEVEL(AF), .CW(CW)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .almost_full(almost_full), .b_rdy(b_rdy), .dout(dout), .dout_vld(dout_vld),
    .usedw(usedw), .empty(empty), .full(full), .clr_stat(clr_stat),
    .drop_cnt(drop_cnt), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_vld;
  int            m_drop;
  logic          m_ovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare all outputs.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic br,
                      input logic c, input logic r);
    bit was_full;
    bit do_rd;
    bit do_wr;
    din_vld = v; din = d; b_rdy = br; clr_stat = c; rst = r;
    was_full = (q.size() == DEPTH);
    if (r) begin
      q.delete();
      m_dout = '0; m_vld = 1'b0; m_drop = 0; m_ovf = 1'b0;
    end else begin
      do_rd = br && (q.size() > 0);
      do_wr = v && !was_full;
      m_vld = do_rd;
      if (do_rd) m_dout = q.pop_front();
      if (do_wr) q.push_back(d);
      if (c) begin
        m_drop = 0; m_ovf = 1'b0;
      end else if (v && was_full) begin
        if (m_drop < DMAX) m_drop++;
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("usedw",       32'(usedw),       32'(q.size()));
    chk("empty",       32'(empty),       32'(q.size() == 0));
    chk("full",        32'(full),        32'(q.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
    chk("din_rdy",     32'(din_rdy),     32'(q.size() != DEPTH));
    chk("dout_vld",    32'(dout_vld),    32'(m_vld));
    chk("dout",        32'(dout),        32'(m_dout));
    chk("drop_cnt",    32'(drop_cnt),    32'(m_drop));
    chk("ovf_sticky",  32'(ovf_sticky),  32'(m_ovf));
  endtask

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          br;
    logic          c;
    logic          r;
    logic [AW:0]   eu;
    logic          ee;
    logic          ev;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // Write 1..3 with the consumer stalled, then drain back to back.
    tbl[0] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 7'd0, 1'b1, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 7'd1, 1'b0, 1'b0, 16'h0000};
    tbl[2] = '{1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 7'd2, 1'b0, 1'b0, 16'h0000};
    tbl[3] = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 7'd3, 1'b0, 1'b0, 16'h0000};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 7'd2, 1'b0, 1'b1, 16'h0001};
    tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 7'd1, 1'b0, 1'b1, 16'h0002};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 16'h0003};
    tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 16'h0003};

    q.delete();
    m_dout = '0; m_vld = 1'b0; m_drop = 0; m_ovf = 1'b0;
    rst = 1'b1; din = '0; din_vld = 1'b0; b_rdy = 1'b0; clr_stat = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].br, tbl[i].c, tbl[i].r);
      chk("tbl_usedw", 32'(usedw),    32'(tbl[i].eu));
      chk("tbl_empty", 32'(empty),    32'(tbl[i].ee));
      chk("tbl_vld",   32'(dout_vld), 32'(tbl[i].ev));
      chk("tbl_dout",  32'(dout),     32'(tbl[i].ed));
    end

    // Fill to full: almost_full threshold, full, then overflow drops
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, DW'(16'h1000 + i), 1'b0, 1'b0, 1'b0);
      if (i == AF - 2) chk("af_below", 32'(almost_full), 32'd0);
      if (i == AF - 1) chk("af_at",    32'(almost_full), 32'd1);
    end
    chk("fill_full",    32'(full),    32'd1);
    chk("fill_din_rdy", 32'(din_rdy), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'hdead, 1'b0, 1'b0, 1'b0);
    chk("ovf_drop3", 32'(drop_cnt),   32'd3);
    chk("ovf_flag",  32'(ovf_sticky), 32'd1);
    chk("ovf_used",  32'(usedw),      32'd64);

    // Full with write and read together: write dropped, oldest word out
    step(1'b1, 16'hbeef, 1'b1, 1'b0, 1'b0);
    chk("fr_drop",  32'(drop_cnt), 32'd4);
    chk("fr_used",  32'(usedw),    32'd63);
    chk("fr_dout",  32'(dout),     32'h1000);
    chk("fr_vld",   32'(dout_vld), 32'd1);

    // Continuous streaming from empty
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      step(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
      chk("strm_used", 32'(usedw <= 1), 32'd1);
      if (i >= 1) begin
        chk("strm_vld",  32'(dout_vld), 32'd1);
        chk("strm_dout", 32'(dout),     32'(i - 1));
      end
    end

    // Reset with 10 words stored, then nothing stale emerges
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, DW'(16'h2000 + i), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_used", 32'(usedw), 32'd10);
    step(1'b1, 16'h3333, 1'b1, 1'b0, 1'b1);
    chk("rst_used",  32'(usedw),    32'd0);
    chk("rst_empty", 32'(empty),    32'd1);
    chk("rst_dout",  32'(dout),     32'd0);
    chk("rst_vld",   32'(dout_vld), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("post_rst_vld", 32'(dout_vld), 32'd0);
    end

    // Drop counter saturation and clr_stat priority
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
    chk("sat_cnt", 32'(drop_cnt),   32'd15);
    chk("sat_ovf", 32'(ovf_sticky), 32'd1);
    step(1'b1, 16'h5555, 1'b0, 1'b1, 1'b0);
    chk("clr_cnt", 32'(drop_cnt),   32'd0);
    chk("clr_ovf", 32'(ovf_sticky), 32'd0);

    // Randomized run in phases biased toward filling and draining
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int ph = 0; ph < 6; ph++) begin
      int pv;
      int pr;
      pv = (ph % 2 == 0) ? 85 : 30;
      pr = (ph % 2 == 0) ? 30 : 85;
      for (int i = 0; i < 400; i++) begin
        step(($urandom_range(0, 99) < pv),
             DW'($urandom),
             ($urandom_range(0, 99) < pr),
             ($urandom_range(0, 99) < 2),
             ($urandom_range(0, 999) < 2));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
